ptw_arbiter: RTL and testbench

- Shares one page table walker between NUM_CLIENTS TLBs (default: instruction TLB on client 0, data TLB on client 1).
- Accepts TLB miss walk requests using round-robin arbitration and forwards one walk at a time to the PTW.
- Routes the returned PTE back to the requesting TLB.
- Has an optional timeout. On timeout the client gets a zero PTE, which every TLB treats as a fault.

---
 rtl/ptw_arb_pkg.sv | 17 +
 rtl/ptw_arbiter_ptw_rr_pick.sv | 35 +++
 rtl/ptw_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ptw_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ptw_arb_pkg.sv
// Shared types and constants for the page-table-walker arbiter.
package ptw_arb_pkg;

    localparam int unsigned VADDR_W = 32;
    localparam int unsigned PTE_W   = 32;

    // A zero PTE is treated as a fault by every TLB.
    localparam logic [PTE_W-1:0] FAULT_PTE = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        PTW_REQ,
        PTW_WAIT,
        CL_RESP
    } state_t;

endpackage

// File: rtl/ptw_arbiter_ptw_rr_pick.sv
// Combinational round-robin picker: first requester at or above rr_ptr, wrapping.
module ptw_rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned CID_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [CID_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic [CID_W-1:0] grant_id,
    output logic             any_valid
);

    always_comb begin
        int unsigned      idx;
        logic [CID_W-1:0] sel;
        grant     = '0;
        grant_id  = '0;
        any_valid = 1'b0;
        idx       = 0;
        sel       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            sel = CID_W'(idx);
            if (!any_valid && req[sel]) begin
                any_valid  = 1'b1;
                grant_id   = sel;
                grant[sel] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptw_arbiter.sv
// Shares one page table walker between several TLBs, one walk at a time.
module ptw_arbiter
    import ptw_arb_pkg::*;
#(
    parameter int unsigned NUM_CLIENTS    = 2,
    parameter int unsigned CID_W          = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TMR_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CLIENTS-1:0]         cl_req_valid_i,
    output logic [NUM_CLIENTS-1:0]         cl_req_ready_o,
    input  logic [VADDR_W*NUM_CLIENTS-1:0] cl_vaddr_i,
    output logic [NUM_CLIENTS-1:0]         cl_resp_valid_o,
    input  logic [NUM_CLIENTS-1:0]         cl_resp_ready_i,
    output logic [PTE_W-1:0]               cl_pte_o,
    output logic                           ptw_req_valid_o,
    input  logic                           ptw_req_ready_i,
    output logic [VADDR_W-1:0]             ptw_vaddr_o,
    input  logic                           ptw_resp_valid_i,
    output logic                           ptw_resp_ready_o,
    input  logic [PTE_W-1:0]               ptw_pte_i,
    output logic                           busy_o,
    output logic                           timeout_o
);

    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CID_W-1:0] LAST_ID  = CID_W'(NUM_CLIENTS - 1);

    state_t                   state, state_nxt;
    logic [CID_W-1:0]         rr_ptr, rr_nxt;
    logic [CID_W-1:0]         cur_id, cur_nxt;
    logic [VADDR_W-1:0]       vaddr_reg, vaddr_nxt;
    logic [PTE_W-1:0]         pte_reg, pte_nxt;
    logic [TMR_W-1:0]         timer, timer_nxt;
    logic                     late_pending, late_nxt;
    logic                     req_valid_q, req_valid_nxt;
    logic                     resp_ready_q, resp_ready_nxt;
    logic [NUM_CLIENTS-1:0]   cl_valid_q, cl_valid_nxt;
    logic                     timeout_q, timeout_nxt;

    logic [NUM_CLIENTS-1:0]   grant;
    logic [CID_W-1:0]         grant_id;
    logic                     any_valid;
    logic                     grant_en;
    logic [VADDR_W-1:0]       grant_vaddr;
    logic [NUM_CLIENTS-1:0]   cur_oh;

    ptw_rr_pick #(
        .N     (NUM_CLIENTS),
        .CID_W (CID_W)
    ) u_pick (
        .req       (cl_req_valid_i),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_valid (any_valid)
    );

    // Grants are withheld while a timed-out walk's late response is still owed.
    assign grant_en       = !rst && (state == IDLE) && !late_pending;
    assign cl_req_ready_o = grant_en ? grant : '0;
    assign cur_oh         = NUM_CLIENTS'(1) << cur_id;

    always_comb begin
        grant_vaddr = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (grant[k]) begin
                grant_vaddr = cl_vaddr_i[k*VADDR_W +: VADDR_W];
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        rr_nxt         = rr_ptr;
        cur_nxt        = cur_id;
        vaddr_nxt      = vaddr_reg;
        pte_nxt        = pte_reg;
        timer_nxt      = timer;
        late_nxt       = late_pending;
        req_valid_nxt  = req_valid_q;
        resp_ready_nxt = resp_ready_q;
        cl_valid_nxt   = cl_valid_q;
        timeout_nxt    = 1'b0;

        case (state)
            IDLE: begin
                if (grant_en && any_valid) begin
                    cur_nxt       = grant_id;
                    vaddr_nxt     = grant_vaddr;
                    req_valid_nxt = 1'b1;
                    state_nxt     = PTW_REQ;
                end
            end
            PTW_REQ: begin
                if (ptw_req_ready_i) begin
                    req_valid_nxt  = 1'b0;
                    resp_ready_nxt = 1'b1;
                    timer_nxt      = '0;
                    state_nxt      = PTW_WAIT;
                end
            end
            PTW_WAIT: begin
                // A response on the timeout cycle takes precedence over the fault.
                if (ptw_resp_valid_i) begin
                    pte_nxt        = ptw_pte_i;
                    resp_ready_nxt = 1'b0;
                    cl_valid_nxt   = cur_oh;
                    state_nxt      = CL_RESP;
                end else if (TO_EN && (timer == TMR_LAST)) begin
                    pte_nxt      = FAULT_PTE;
                    timeout_nxt  = 1'b1;
                    late_nxt     = 1'b1;
                    cl_valid_nxt = cur_oh;
                    state_nxt    = CL_RESP;
                end else begin
                    timer_nxt = timer + TMR_W'(1);
                end
            end
            CL_RESP: begin
                if (cl_resp_ready_i[cur_id]) begin
                    cl_valid_nxt = '0;
                    rr_nxt       = (cur_id == LAST_ID) ? '0 : cur_id + CID_W'(1);
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Swallow the late response of a timed-out walk, whatever state we are in.
        if (late_pending && ptw_resp_valid_i) begin
            late_nxt       = 1'b0;
            resp_ready_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cur_id       <= '0;
            vaddr_reg    <= '0;
            pte_reg      <= '0;
            timer        <= '0;
            late_pending <= 1'b0;
            req_valid_q  <= 1'b0;
            resp_ready_q <= 1'b0;
            cl_valid_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state        <= state_nxt;
            rr_ptr       <= rr_nxt;
            cur_id       <= cur_nxt;
            vaddr_reg    <= vaddr_nxt;
            pte_reg      <= pte_nxt;
            timer        <= timer_nxt;
            late_pending <= late_nxt;
            req_valid_q  <= req_valid_nxt;
            resp_ready_q <= resp_ready_nxt;
            cl_valid_q   <= cl_valid_nxt;
            timeout_q    <= timeout_nxt;
        end
    end

    assign ptw_req_valid_o  = req_valid_q;
    assign ptw_vaddr_o      = vaddr_reg;
    assign ptw_resp_ready_o = resp_ready_q;
    assign cl_resp_valid_o  = cl_valid_q;
    assign cl_pte_o         = pte_reg;
    assign timeout_o        = timeout_q;
    assign busy_o           = (state != IDLE) || late_pending;

endmodule

// File: tb/tb_ptw_arbiter.sv
// Directed scoreboard bench for ptw_arbiter with two clients and an 8-cycle timeout.
module tb_ptw_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cl_req_valid;
    logic [1:0]  cl_req_ready_o;
    logic [63:0] cl_vaddr;
    logic [1:0]  cl_resp_valid_o;
    logic [1:0]  cl_resp_ready;
    logic [31:0] cl_pte_o;
    logic        ptw_req_valid_o;
    logic        ptw_req_ready;
    logic [31:0] ptw_vaddr_o;
    logic        ptw_resp_valid;
    logic        ptw_resp_ready_o;
    logic [31:0] ptw_pte;
    logic        busy_o;
    logic        timeout_o;

    typedef struct {
        int          id;
        logic [31:0] pte;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    ptw_arbiter #(
        .NUM_CLIENTS    (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cl_req_valid_i   (cl_req_valid),
        .cl_req_ready_o   (cl_req_ready_o),
        .cl_vaddr_i       (cl_vaddr),
        .cl_resp_valid_o  (cl_resp_valid_o),
        .cl_resp_ready_i  (cl_resp_ready),
        .cl_pte_o         (cl_pte_o),
        .ptw_req_valid_o  (ptw_req_valid_o),
        .ptw_req_ready_i  (ptw_req_ready),
        .ptw_vaddr_o      (ptw_vaddr_o),
        .ptw_resp_valid_i (ptw_resp_valid),
        .ptw_resp_ready_o (ptw_resp_ready_o),
        .ptw_pte_i        (ptw_pte),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] oh(input int id);
        return 2'(1) << id;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Wait (bounded) for a client response, then pop and compare the scoreboard head.
    task automatic collect(input int max_wait, input int exp_wait, input string tag);
        int   w;
        exp_t e;
        w = 0;
        while (cl_resp_valid_o == 2'b00 && w < max_wait) begin
            step();
            w++;
        end
        chk({tag, "_latency"}, 32'(w), 32'(exp_wait));
        n_checks++;
        assert (sb.size() > 0) n_pass++;
        else $error("FAIL %s_sb observed=empty expected=entry", tag);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(cl_resp_valid_o), 32'(oh(e.id)));
            chk({tag, "_pte"}, cl_pte_o, e.pte);
        end
    endtask

    // One complete walk, entered in IDLE with the requesting client(s) already valid.
    task automatic do_walk(input int id, input logic [31:0] va, input logic [31:0] pte,
                           input int resp_delay, input int req_stall, input int resp_hold,
                           input logic [1:0] drop);
        #1;
        chk("grant", 32'(cl_req_ready_o), 32'(oh(id)));
        sb.push_back('{id, pte});
        step();
        cl_req_valid = cl_req_valid & ~drop;
        chk("ptw_req_valid", 32'(ptw_req_valid_o), 32'd1);
        chk("ptw_vaddr", ptw_vaddr_o, va);
        chk("busy", 32'(busy_o), 32'd1);
        for (int i = 0; i < req_stall; i++) begin
            step();
            chk("stall_req_valid", 32'(ptw_req_valid_o), 32'd1);
            chk("stall_vaddr", ptw_vaddr_o, va);
            chk("stall_no_grant", 32'(cl_req_ready_o), 32'd0);
        end
        ptw_req_ready = 1'b1;
        step();
        ptw_req_ready = 1'b0;
        chk("ptw_req_clear", 32'(ptw_req_valid_o), 32'd0);
        chk("ptw_resp_ready", 32'(ptw_resp_ready_o), 32'd1);
        repeat (resp_delay) step();
        ptw_resp_valid = 1'b1;
        ptw_pte        = pte;
        step();
        ptw_resp_valid = 1'b0;
        collect(2, 0, "resp");
        chk("no_timeout", 32'(timeout_o), 32'd0);
        chk("ptw_resp_ready_clr", 32'(ptw_resp_ready_o), 32'd0);
        cl_resp_ready = ~oh(id);
        for (int i = 0; i < resp_hold; i++) begin
            step();
            chk("hold_valid", 32'(cl_resp_valid_o), 32'(oh(id)));
            chk("hold_pte", cl_pte_o, pte);
            chk("hold_no_grant", 32'(cl_req_ready_o), 32'd0);
        end
        cl_resp_ready = oh(id);
        step();
        cl_resp_ready = 2'b00;
        chk("resp_done", 32'(cl_resp_valid_o), 32'd0);
        chk("idle_not_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        cl_req_valid   = 2'b11;
        cl_vaddr       = '0;
        cl_resp_ready  = 2'b00;
        ptw_req_ready  = 1'b0;
        ptw_resp_valid = 1'b0;
        ptw_pte        = '0;

        // Reset state: everything quiet even with requests present.
        #2;
        chk("rst_req_ready", 32'(cl_req_ready_o), 32'd0);
        chk("rst_ptw_req", 32'(ptw_req_valid_o), 32'd0);
        chk("rst_vaddr", ptw_vaddr_o, 32'd0);
        chk("rst_resp_valid", 32'(cl_resp_valid_o), 32'd0);
        chk("rst_pte", cl_pte_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        cl_req_valid = 2'b00;
        rst          = 1'b0;

        // Single request from client 1.
        cl_vaddr[63:32] = 32'h12345ABC;
        cl_req_valid    = 2'b10;
        do_walk(1, 32'h12345ABC, 32'hABCDE003, 3, 0, 0, 2'b10);

        // Contention: both clients requesting, grants alternate 0,1,0,1.
        cl_vaddr     = {32'hB0000000, 32'hA0000000};
        cl_req_valid = 2'b11;
        do_walk(0, 32'hA0000000, 32'h10000001, 1, 0, 0, 2'b00);
        do_walk(1, 32'hB0000000, 32'h10000002, 2, 0, 0, 2'b00);
        do_walk(0, 32'hA0000000, 32'h10000003, 0, 0, 0, 2'b00);
        do_walk(1, 32'hB0000000, 32'h10000004, 1, 0, 0, 2'b11);

        // Backpressure on both sides with client 1 waiting behind client 0.
        cl_vaddr     = {32'hB1110000, 32'hA1110000};
        cl_req_valid = 2'b11;
        do_walk(0, 32'hA1110000, 32'h20000005, 2, 4, 5, 2'b01);
        do_walk(1, 32'hB1110000, 32'h20000006, 0, 0, 0, 2'b10);

        // Timeout: PTW never answers in time; client 0 gets a fault PTE.
        cl_vaddr[31:0] = 32'hCAFE0000;
        cl_req_valid   = 2'b01;
        #1;
        chk("to_grant", 32'(cl_req_ready_o), 32'd1);
        step();
        cl_req_valid  = 2'b00;
        ptw_req_ready = 1'b1;
        step();
        ptw_req_ready = 1'b0;
        sb.push_back('{0, 32'h0});
        collect(20, 8, "timeout");
        chk("timeout_pulse", 32'(timeout_o), 32'd1);
        cl_resp_ready = 2'b01;
        step();
        cl_resp_ready = 2'b00;
        chk("timeout_one_cycle", 32'(timeout_o), 32'd0);
        chk("late_busy", 32'(busy_o), 32'd1);
        chk("late_resp_ready", 32'(ptw_resp_ready_o), 32'd1);
        cl_req_valid = 2'b01;
        for (int i = 0; i < 11; i++) begin
            step();
            chk("late_no_grant", 32'(cl_req_ready_o), 32'd0);
        end
        ptw_resp_valid = 1'b1;
        ptw_pte        = 32'hDEADBEEF;
        #1;
        chk("late_no_grant_same", 32'(cl_req_ready_o), 32'd0);
        step();
        ptw_resp_valid = 1'b0;
        chk("late_not_forwarded", 32'(cl_resp_valid_o), 32'd0);
        chk("late_ready_clr", 32'(ptw_resp_ready_o), 32'd0);
        chk("late_cleared", 32'(busy_o), 32'd0);
        chk("late_grant", 32'(cl_req_ready_o), 32'd1);
        do_walk(0, 32'hCAFE0000, 32'h0BEEF007, 1, 0, 0, 2'b01);

        // Async reset in PTW_WAIT with client 1 walking (rr_ptr is 1 here).
        cl_vaddr[63:32] = 32'h77770000;
        cl_req_valid    = 2'b10;
        #1;
        chk("pre_rst_grant", 32'(cl_req_ready_o), 32'd2);
        step();
        ptw_req_ready = 1'b1;
        step();
        ptw_req_ready = 1'b0;
        step();
        cl_req_valid = 2'b11;
        #3;
        rst = 1'b1;
        #1;
        chk("arst_req_ready", 32'(cl_req_ready_o), 32'd0);
        chk("arst_resp_ready", 32'(ptw_resp_ready_o), 32'd0);
        chk("arst_vaddr", ptw_vaddr_o, 32'd0);
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_pte", cl_pte_o, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        do_walk(0, 32'hCAFE0000, 32'h30000008, 1, 0, 0, 2'b01);
        do_walk(1, 32'h77770000, 32'h30000009, 2, 0, 0, 2'b10);

        // Response lands exactly on the timeout cycle.
        cl_req_valid = 2'b10;
        do_walk(1, 32'h77770000, 32'h5A5A5003, 7, 0, 0, 2'b10);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
